divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ena, input, 1 bit: stage enable; 0 freezes all state (pipeline stall).
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE with ena=1.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU.
REQ-006 SHALL have port dividend, input, 32 bits: numerator, latched on an accepted start.
REQ-007 SHALL have port divisor, input, 32 bits: denominator, latched on an accepted start.
REQ-008 SHALL have port q, output, 32 bits: quotient (LO source for the downstream result MUX2).
REQ-009 SHALL have port r, output, 32 bits: remainder (HI source for the downstream result MUX2).
REQ-010 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse when q and r become valid.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE with ena=1 and start=1 at edge k, latch operands and is_signed, load |dividend| and |divisor| (magnitudes computed only when is_signed=1), clear the 5-bit iteration counter, and go to CALC.
REQ-014 SHALL, in CALC with ena=1, perform one restoring shift-subtract step per edge (32 steps, MSB first), using a 33-bit partial remainder so that no carry is lost.
REQ-015 SHALL, at the edge completing step 32 (edge k+32 with no stall), register final q and r, go to DONE, drive done=1 and drive busy=0.
REQ-016 SHALL, in DONE with ena=1, return to IDLE on the next edge and drop done to 0; start is ignored while in DONE.
REQ-017 SHALL, in signed mode, negate the quotient magnitude when dividend[31]^divisor[31]=1 and negate the remainder magnitude when dividend[31]=1.
REQ-018 SHALL return q=0x80000000 and r=0 for signed 0x80000000 / 0xFFFFFFFF, without any trap or flag.
REQ-019 SHALL, when divisor==0 in either mode, produce q=0xFFFFFFFF and r=the raw latched dividend, bypassing sign correction, with the same 32-cycle latency.
REQ-020 SHALL hold q and r stable from DONE until the next DONE; outputs SHALL NOT change during CALC.
REQ-021 SHALL ignore start while busy=1, and SHALL ignore changes to dividend, divisor and is_signed after the operands are latched.
REQ-022 SHALL, with ena=0 in any state, hold state, counter, operands, q, r, busy and done unchanged, so that each stall cycle extends latency by one.

Reset
REQ-023 SHALL, when rst=1 at an edge, regardless of ena or state (including mid-CALC), set state to IDLE, the counter to 0, q to 0, r to 0, busy to 0 and done to 0.
REQ-024 SHALL abandon an aborted division and SHALL accept a new start on the first edge after rst deasserts.

Verification
REQ-025 SHALL pass this case: unsigned 100/7 with start at edge k -> busy=1 for edges k..k+31, done=1 after edge k+32, q=14, r=2.
REQ-026 SHALL pass this case: signed -7/2 (0xFFFFFFF9/0x00000002) -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=0x00000001.
REQ-027 SHALL pass this case: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/0x00000001 -> q=0xFFFFFFFF, r=0.
REQ-028 SHALL pass this case: divide by zero, unsigned 5/0 -> q=0xFFFFFFFF, r=5; signed 0xFFFFFFFB/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB; done still at edge k+32.
REQ-029 SHALL pass this case: ena=0 for 5 cycles mid-CALC and a start pulse plus operand change while busy -> done at edge k+37 with the original operands' result, and the second start is not honoured.
REQ-030 SHALL pass this case: rst at edge k+10 of a division -> q=r=0, busy=done=0 at the next cycle; a new 100/7 started immediately afterwards completes correctly 32 edges later.

Source files
------------

// File: rtl/divider.sv
// 32-bit iterative restoring divider (DIV/DIVU): 32 shift-subtract steps,
// sign correction on completion, divide-by-zero returns all-ones / raw dividend.
module divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] q,
   output logic [31:0] r,
   output logic        busy,
   output logic        done
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [W-1:0]    dvs_q, dvs_d;
   logic [W-1:0]    raw_q, raw_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            dzero_q, dzero_d;
   logic [W-1:0]    q_q, q_d;
   logic [W-1:0]    r_q, r_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [W:0]      rem_sh;
   logic [W:0]      diff;
   logic            step_ge;
   logic [W-1:0]    rem_nx;
   logic [W-1:0]    quo_nx;
   logic [W-1:0]    abs_dvd;
   logic [W-1:0]    abs_dvs;

   // One restoring step: shift in next dividend bit, subtract if it fits
   always_comb begin
      rem_sh  = {rem_q, quo_q[W-1]};
      diff    = rem_sh - {1'b0, dvs_q};
      step_ge = ~diff[W];
      rem_nx  = step_ge ? diff[W-1:0] : rem_sh[W-1:0];
      quo_nx  = {quo_q[W-2:0], step_ge};
      abs_dvd = (is_signed && dividend[W-1]) ? W'(-dividend) : dividend;
      abs_dvs = (is_signed && divisor[W-1])  ? W'(-divisor)  : divisor;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      raw_d     = raw_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dzero_d   = dzero_q;
      q_d       = q_q;
      r_d       = r_q;
      busy_d    = busy_q;
      done_d    = done_q;
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  cnt_d     = '0;
                  rem_d     = '0;
                  quo_d     = abs_dvd;
                  dvs_d     = abs_dvs;
                  raw_d     = dividend;
                  neg_quo_d = is_signed & (dividend[W-1] ^ divisor[W-1]);
                  neg_rem_d = is_signed & dividend[W-1];
                  dzero_d   = (divisor == '0);
                  busy_d    = 1'b1;
                  state_d   = CALC;
               end
            end
            CALC: begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = CW'(cnt_q + 1'b1);
               if (cnt_q == CW'(W - 1)) begin
                  // Zero divisor bypasses sign correction entirely
                  if (dzero_q) begin
                     q_d = '1;
                     r_d = raw_q;
                  end else begin
                     q_d = neg_quo_q ? W'(-quo_nx) : quo_nx;
                     r_d = neg_rem_q ? W'(-rem_nx) : rem_nx;
                  end
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         raw_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dzero_q   <= 1'b0;
         q_q       <= '0;
         r_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         raw_q     <= raw_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dzero_q   <= dzero_d;
         q_q       <= q_d;
         r_q       <= r_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: timing, signed/unsigned results,
// overflow, divide-by-zero, stall, reset abort and back-to-back operation.
module tb_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] q;
   logic [31:0] r;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   divider dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .q         (q),
      .r         (r),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Drives one division; lat = edges from the accepting edge to done, nb = busy samples
   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nb);
      @(negedge clk);
      is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; nb = 0;
      while (!done && lat < 100) begin
         if (busy) nb++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; ena = 1'b1; start = 1'b0; is_signed = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({q, r, busy, done} !== 66'd0) begin
         n_bad++;
         $display("FAIL reset: q=%h r=%h busy=%b done=%b, need all zero", q, r, busy, done);
      end
      rst = 1'b0;
   endtask

   task automatic test_unsigned;
      int lat, nb;
      do_div(1'b0, 32'd100, 32'd7, lat, nb);
      n_cmp++;
      if (lat !== 32 || nb !== 32) begin
         n_bad++;
         $display("FAIL udiv_timing: done_edge=%0d busy_cycles=%0d, need 32/32", lat, nb);
      end
      n_cmp++;
      if (q !== 32'd14 || r !== 32'd2 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL udiv_100_7: q=%0d r=%0d busy=%b, need 14 2 0", q, r, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || q !== 32'd14 || r !== 32'd2) begin
         n_bad++;
         $display("FAIL done_pulse: done=%b q=%0d r=%0d, need 0 14 2", done, q, r);
      end
   endtask

   task automatic test_vectors;
      logic [31:0] va [8] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFF9C};
      logic [31:0] vb [8] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001,
                              32'h00000010, 32'hFFFFFFFF, 32'h00000009, 32'h00000007};
      logic        vs [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] eq [8] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                              32'h0FFFFFFF, 32'h00000000, 32'h00000000, 32'h24924916};
      logic [31:0] er [8] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000,
                              32'h0000000F, 32'h80000000, 32'h00000000, 32'h00000002};
      int lat, nb;
      for (int i = 0; i < 8; i++) begin
         do_div(vs[i], va[i], vb[i], lat, nb);
         n_cmp++;
         if (q !== eq[i] || r !== er[i] || lat !== 32) begin
            n_bad++;
            $display("FAIL vec%0d: q=%h r=%h lat=%0d, need q=%h r=%h lat=32",
                     i, q, r, lat, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      int lat, nb;
      do_div(1'b0, 32'd5, 32'd0, lat, nb);
      n_cmp++;
      if (q !== 32'hFFFFFFFF || r !== 32'd5 || lat !== 32) begin
         n_bad++;
         $display("FAIL udiv_zero: q=%h r=%h lat=%0d, need ffffffff 5 32", q, r, lat);
      end
      do_div(1'b1, 32'hFFFFFFFB, 32'd0, lat, nb);
      n_cmp++;
      if (q !== 32'hFFFFFFFF || r !== 32'hFFFFFFFB || lat !== 32) begin
         n_bad++;
         $display("FAIL sdiv_zero: q=%h r=%h lat=%0d, need ffffffff fffffffb 32", q, r, lat);
      end
   endtask

   // 1000/3 with a 5-cycle stall and an ignored start plus operand change while busy
   task automatic test_stall;
      int lat;
      logic [31:0] q_prev;
      q_prev = q;
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         if (lat == 5)  ena = 1'b0;
         if (lat == 10) ena = 1'b1;
         if (lat == 15) begin
            start = 1'b1; is_signed = 1'b1; dividend = 32'd5; divisor = 32'd0;
         end
         if (lat == 16) start = 1'b0;
         if (lat == 20) begin
            n_cmp++;
            if (q !== q_prev || busy !== 1'b1) begin
               n_bad++;
               $display("FAIL hold_in_calc: q=%h busy=%b, need %h 1", q, busy, q_prev);
            end
         end
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (lat !== 37 || q !== 32'd333 || r !== 32'd1) begin
         n_bad++;
         $display("FAIL stall: lat=%0d q=%0d r=%0d, need 37 333 1", lat, q, r);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_start: busy=%b done=%b, need 0 0", busy, done);
      end
   endtask

   task automatic test_rst_abort;
      int lat, nb;
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({q, r, busy, done} !== 66'd0) begin
         n_bad++;
         $display("FAIL abort_reset: q=%h r=%h busy=%b done=%b, need all zero", q, r, busy, done);
      end
      rst = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (lat !== 32 || q !== 32'd14 || r !== 32'd2) begin
         n_bad++;
         $display("FAIL post_reset_div: lat=%0d q=%0d r=%0d, need 32 14 2", lat, q, r);
      end
   endtask

   task automatic test_back_to_back;
      int lat, nb;
      do_div(1'b1, 32'hFFFFFF9C, 32'd10, lat, nb);
      n_cmp++;
      if (q !== 32'hFFFFFFF6 || r !== 32'd0) begin
         n_bad++;
         $display("FAIL b2b_first: q=%h r=%h, need fffffff6 0", q, r);
      end
      // start asserted while in DONE must be dropped
      start = 1'b1; dividend = 32'd9; divisor = 32'd4; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL start_in_done: busy=%b done=%b, need 0 0", busy, done);
      end
      do_div(1'b0, 32'd9, 32'd4, lat, nb);
      n_cmp++;
      if (q !== 32'd2 || r !== 32'd1 || lat !== 32) begin
         n_bad++;
         $display("FAIL b2b_second: q=%0d r=%0d lat=%0d, need 2 1 32", q, r, lat);
      end
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_vectors;
      test_div_zero;
      test_stall;
      test_rst_abort;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
